// File: rtl/mcm_collect.sv
// mcm_collect: gathers one MCM frame from the byte receiver into the MCM RAM.
// A rising edge on iStart launches a one-clk oReq to the MCM. The block then
// waits for the SYNC byte, stores FRAME_LEN data bytes at addresses
// 0..FRAME_LEN-1 and checks the trailing XOR checksum byte. After that it
// holds oDone until the next start edge.
// If the MCM goes quiet for TIMEOUT clks, the rest of the frame is written
// with FILL bytes and oErrTimeout is flagged.
//
// Receive handshake: iRxValid is a one-clk strobe with no back-pressure. A
// byte is consumed in every cycle where iRxValid is high, and back-to-back
// strobes are legal. RAM writes come out one clk later: oWren, oWrAddr and
// oWrData are all registered, and oWren is high for exactly one clk per byte.
module mcm_collect #(
    parameter int          FRAME_LEN = 144,
    parameter logic [7:0]  SYNC      = 8'hA5,
    parameter logic [7:0]  FILL      = 8'h00,
    parameter int          TIMEOUT   = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iStart,
    input  logic [7:0] iRxData,
    input  logic       iRxValid,
    output logic       oReq,
    output logic [7:0] oWrAddr,
    output logic [7:0] oWrData,
    output logic       oWren,
    output logic       oDone,
    output logic       oErrTimeout,
    output logic       oErrSum,
    output logic [2:0] oState
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_SYNC = 3'd2,
        S_COLLECT   = 3'd3,
        S_SUM       = 3'd4,
        S_FILL      = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    // The counter is 9 bits wide. With FRAME_LEN=256 it still compares
    // correctly against the last address (255) before the SUM transition.
    localparam logic [8:0]  LAST_ADDR = 9'(FRAME_LEN - 1);
    localparam logic [19:0] TO_LAST   = 20'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_start_d;
    logic [8:0]  r_cnt;
    logic [7:0]  r_acc;
    logic [19:0] r_tcnt;

    logic        w_start_edge;
    logic        w_tmo;

    assign w_start_edge = iStart & ~r_start_d;
    assign w_tmo        = (r_tcnt == TO_LAST);
    assign oState       = r_state;

    // Frame collection FSM with registered RAM-write and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_start_d   <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_tcnt      <= '0;
            oReq        <= 1'b0;
            oWrAddr     <= '0;
            oWrData     <= '0;
            oWren       <= 1'b0;
            oDone       <= 1'b0;
            oErrTimeout <= 1'b0;
            oErrSum     <= 1'b0;
        end else begin
            r_start_d <= iStart;
            oReq      <= 1'b0;
            oWren     <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // A start edge releases the packer and arms a new frame.
                    if (w_start_edge) begin
                        r_state     <= S_REQ;
                        oReq        <= 1'b1;
                        oDone       <= 1'b0;
                        oErrTimeout <= 1'b0;
                        oErrSum     <= 1'b0;
                        r_cnt       <= '0;
                        r_acc       <= '0;
                        r_tcnt      <= '0;
                    end
                end
                S_REQ: begin
                    r_state <= S_WAIT_SYNC;
                end
                S_WAIT_SYNC: begin
                    if (iRxValid) begin
                        r_tcnt <= '0;
                        if (iRxData == SYNC) begin
                            r_state <= S_COLLECT;
                        end
                    end else if (w_tmo) begin
                        oErrTimeout <= 1'b1;
                        r_state     <= S_FILL;
                    end else begin
                        r_tcnt <= r_tcnt + 20'd1;
                    end
                end
                S_COLLECT: begin
                    // Bytes equal to SYNC are plain data in this state.
                    if (iRxValid) begin
                        r_tcnt  <= '0;
                        oWren   <= 1'b1;
                        oWrAddr <= r_cnt[7:0];
                        oWrData <= iRxData;
                        r_acc   <= r_acc ^ iRxData;
                        r_cnt   <= r_cnt + 9'd1;
                        if (r_cnt == LAST_ADDR) begin
                            r_state <= S_SUM;
                        end
                    end else if (w_tmo) begin
                        oErrTimeout <= 1'b1;
                        r_state     <= S_FILL;
                    end else begin
                        r_tcnt <= r_tcnt + 20'd1;
                    end
                end
                S_SUM: begin
                    // The checksum byte is compared only; it is never written.
                    if (iRxValid) begin
                        r_tcnt  <= '0;
                        oErrSum <= (iRxData != r_acc);
                        oDone   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_tmo) begin
                        oErrTimeout <= 1'b1;
                        oDone       <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 20'd1;
                    end
                end
                S_FILL: begin
                    // Pad the remaining addresses, one per clk. Input is ignored.
                    oWren   <= 1'b1;
                    oWrAddr <= r_cnt[7:0];
                    oWrData <= FILL;
                    r_cnt   <= r_cnt + 9'd1;
                    if (r_cnt == LAST_ADDR) begin
                        oDone   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcm_collect.sv
// Testbench for mcm_collect. It drives whole frames as byte streams. A
// reference model derives the expected RAM writes and final flags from the
// stream, and a negedge monitor checks every write and every oDone rise
// against the expected queues.
module tb_mcm_collect;

    localparam int         FRAME_LEN = 144;
    localparam logic [7:0] SYNC      = 8'hA5;
    localparam logic [7:0] FILL      = 8'h00;
    localparam int         TIMEOUT   = 64;

    // clock / reset
    logic       clk;
    logic       reset;
    logic       iStart;
    logic [7:0] iRxData;
    logic       iRxValid;
    logic       oReq;
    logic [7:0] oWrAddr;
    logic [7:0] oWrData;
    logic       oWren;
    logic       oDone;
    logic       oErrTimeout;
    logic       oErrSum;
    logic [2:0] oState;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mcm_collect #(
        .FRAME_LEN (FRAME_LEN),
        .SYNC      (SYNC),
        .FILL      (FILL),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iStart      (iStart),
        .iRxData     (iRxData),
        .iRxValid    (iRxValid),
        .oReq        (oReq),
        .oWrAddr     (oWrAddr),
        .oWrData     (oWrData),
        .oWren       (oWren),
        .oDone       (oDone),
        .oErrTimeout (oErrTimeout),
        .oErrSum     (oErrSum),
        .oState      (oState)
    );

    // scoreboard state
    // exp_q entry: {must_follow_previous_write, addr, data}
    logic [16:0] exp_q[$];
    // done_q entry: {oErrTimeout, oErrSum}
    logic [1:0]  done_q[$];
    logic [7:0]  stim[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          last_wr  = 0;
    int          req_seen = 0;
    int          exp_reqs = 0;
    logic        prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // monitor
    always @(negedge clk) begin
        logic [16:0] e;
        logic [1:0]  d;
        if (reset) begin
            if (oReq) req_seen++;
            if (oWren) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, none expected", oWrAddr, oWrData);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {24'd0, oWrAddr}, {24'd0, e[15:8]});
                    chk("wr_data", {24'd0, oWrData}, {24'd0, e[7:0]});
                    if (e[16]) chk("fill_consecutive", cyc - last_wr, 1);
                    last_wr = cyc;
                end
            end
            if (oDone && !prev_done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: oDone rose with none expected");
                end else begin
                    d = done_q.pop_front();
                    chk("err_timeout", {31'd0, oErrTimeout}, {31'd0, d[1]});
                    chk("err_sum", {31'd0, oErrSum}, {31'd0, d[0]});
                end
            end
        end
        prev_done = oDone;
    end

    // Reference model: interprets the byte stream the way the frame format is
    // defined. Everything before the first SYNC is dropped, the next FRAME_LEN
    // bytes are data, and the byte after them is the checksum. A stream that
    // ends early is padded with FILL and flagged as a timeout.
    task automatic model_frame();
        int         i;
        int         first_fill;
        logic [7:0] x;
        logic       timed_out;
        i = 0;
        x = 8'h00;
        first_fill = -1;
        while (i < stim.size() && stim[i] != SYNC) i++;
        i++;
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (i + k < stim.size()) begin
                exp_q.push_back({1'b0, 8'(k), stim[i + k]});
                x = x ^ stim[i + k];
            end else begin
                if (first_fill < 0) first_fill = k;
                exp_q.push_back({(k != first_fill), 8'(k), FILL});
            end
        end
        timed_out = (first_fill >= 0) || (i + FRAME_LEN >= stim.size());
        if (timed_out) done_q.push_back(2'b10);
        else           done_q.push_back({1'b0, stim[i + FRAME_LEN] != x});
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        iStart = 1'b1;
        tick();
        exp_reqs++;
        chk("req_rise", {31'd0, oReq}, 1);
        chk("done_cleared", {31'd0, oDone}, 0);
        chk("flags_cleared", {30'd0, oErrTimeout, oErrSum}, 0);
        iStart = 1'b0;
        tick();
        chk("req_one_clk", {31'd0, oReq}, 0);
    endtask

    // Streams stim with random idle gaps. If glitch_at is reached, a second
    // start pulse is raised there and must be ignored.
    task automatic send_stim(input int glitch_at);
        for (int j = 0; j < stim.size(); j++) begin
            if (j == glitch_at)     iStart = 1'b1;
            if (j == glitch_at + 2) iStart = 1'b0;
            iRxData  = stim[j];
            iRxValid = 1'b1;
            tick();
            iRxValid = 1'b0;
            if (j != stim.size() - 1) repeat ($urandom_range(0, 3)) tick();
        end
        iStart = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!oDone && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", {31'd0, oDone}, 1);
        tick();
        tick();
        chk("exp_q_drained", exp_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
    endtask

    task automatic build_nominal(input logic bad_sum);
        logic [7:0] x;
        x = 8'h00;
        stim.delete();
        stim.push_back(SYNC);
        for (int k = 0; k < FRAME_LEN; k++) begin
            stim.push_back(8'(k));
            x = x ^ 8'(k);
        end
        stim.push_back(bad_sum ? (x ^ 8'h01) : x);
    endtask

    task automatic run_full(input int glitch_at, input logic check_done_timing);
        do_start();
        model_frame();
        send_stim(glitch_at);
        if (check_done_timing) chk("done_after_sum", {31'd0, oDone}, 1);
        wait_done(2 * TIMEOUT + 4 * FRAME_LEN + 50);
    endtask

    // main stimulus
    initial begin
        logic [7:0] x;
        logic [7:0] v;
        reset    = 1'b0;
        iStart   = 1'b0;
        iRxData  = 8'h00;
        iRxValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {13'd0, oReq, oWren, oDone, oErrTimeout, oErrSum, oWrAddr, oWrData, oState},
            0);
        reset = 1'b1;
        tick();

        // Nominal frame.
        build_nominal(1'b0);
        run_full(-1, 1'b1);

        // Bad checksum; this also restarts from DONE.
        build_nominal(1'b1);
        run_full(-1, 1'b1);

        // Leading garbage, SYNC-valued data byte, second start during COLLECT.
        build_nominal(1'b0);
        x = 8'h00;
        for (int k = 0; k < FRAME_LEN; k++) x = x ^ ((k == 10) ? SYNC : 8'(k));
        stim[11] = SYNC;
        stim[FRAME_LEN + 1] = x;
        stim.push_front(8'h5A);
        stim.push_front(8'h00);
        run_full(40, 1'b1);

        // Timeout mid-frame after 100 data bytes.
        stim.delete();
        stim.push_back(SYNC);
        for (int k = 0; k < 100; k++) stim.push_back(8'(k));
        run_full(-1, 1'b0);

        // Timeout waiting for the checksum byte.
        build_nominal(1'b0);
        void'(stim.pop_back());
        run_full(-1, 1'b0);

        // Random frames with garbage and random checksum outcomes.
        for (int r = 0; r < 3; r++) begin
            stim.delete();
            repeat ($urandom_range(0, 3)) begin
                v = 8'($urandom_range(0, 255));
                stim.push_back((v == SYNC) ? 8'h11 : v);
            end
            stim.push_back(SYNC);
            x = 8'h00;
            for (int k = 0; k < FRAME_LEN; k++) begin
                v = 8'($urandom_range(0, 255));
                stim.push_back(v);
                x = x ^ v;
            end
            stim.push_back(($urandom_range(0, 1) == 1) ? x : (x ^ 8'($urandom_range(1, 255))));
            run_full(-1, 1'b1);
        end

        // Async reset after 50 data bytes.
        do_start();
        for (int k = 0; k < 50; k++) exp_q.push_back({1'b0, 8'(k), 8'(k)});
        stim.delete();
        stim.push_back(SYNC);
        for (int k = 0; k < 50; k++) stim.push_back(8'(k));
        send_stim(-1);
        #6;
        reset = 1'b0;
        #1;
        chk("midframe_reset_outputs",
            {13'd0, oReq, oWren, oDone, oErrTimeout, oErrSum, oWrAddr, oWrData, oState}, 0);
        chk("partial_writes_seen", exp_q.size(), 0);
        tick();
        reset = 1'b1;
        tick();
        build_nominal(1'b0);
        run_full(-1, 1'b1);

        chk("req_count", req_seen, exp_reqs);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mcm_collect.md
# mcm_collect

Upstream stage of the MCM packer. On a start request from the coordinator it collects one MCM frame from the byte-stream receiver into the 8-bit MCM RAM at addresses 0..FRAME_LEN-1, then holds `oDone`. The packer reads the RAM while `oDone` is high and returns to idle when `oDone` falls. The block also checks a trailing XOR checksum and substitutes fill bytes if the MCM stops sending.

## Interface
- `FRAME_LEN`, 144: data bytes per frame (3 streams × 16 × 3 bytes); legal range 1..256.
- `SYNC`, 8'hA5: frame-start byte; not written to RAM.
- `FILL`, 8'h00: byte written to RAM for missing data after a timeout.
- `TIMEOUT`, 100000: maximum clk cycles allowed between request/bytes; counter is 20 bits.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `iStart`  in  1  coordinator request for a new frame; synchronous to clk; acts on its rising edge.
- `iRxData`  in  8  received byte from the byte receiver.
- `iRxValid`  in  1  one-clk strobe; `iRxData` is valid in that cycle.
- `oReq`  out  1  one-clk request pulse to the MCM to send a frame.
- `oWrAddr`  out  8  MCM RAM write address.
- `oWrData`  out  8  MCM RAM write data.
- `oWren`  out  1  MCM RAM write enable, one clk per byte.
- `oDone`  out  1  frame complete in RAM; drives packer `iDone`.
- `oErrTimeout`  out  1  last frame was completed with fill bytes.
- `oErrSum`  out  1  last frame's checksum mismatched.

## Operation
- Reset: all outputs 0, state IDLE, counters 0, checksum accumulator 0, start-edge register 0.
- States: IDLE, REQ, WAIT_SYNC, COLLECT, SUM, FILL, DONE.
- IDLE/DONE:
  - On `iStart` rising edge, go to REQ.
  - In the same cycle clear `oDone`, `oErrTimeout`, `oErrSum`, the byte counter, the accumulator and the timeout counter.
  - Start edges in any other state are ignored.
- REQ: assert `oReq` for exactly 1 clk, then go to WAIT_SYNC.
- WAIT_SYNC: bytes other than `SYNC` are discarded. A `SYNC` byte moves the block to COLLECT.
- COLLECT: each `iRxValid` byte is handled as follows:
  - write it to RAM at address = byte counter;
  - XOR it into the accumulator;
  - increment the counter.
  - After byte FRAME_LEN-1 is written, go to SUM. `SYNC`-valued data bytes are ordinary data.
- SUM: the next valid byte is compared with the accumulator.
  - Mismatch sets `oErrSum`.
  - Either way, go to DONE and set `oDone`. The checksum byte is not written.
- Timeout: in WAIT_SYNC, COLLECT and SUM, the timeout counter increments each clk and clears on every `iRxValid`.
  - On reaching TIMEOUT-1, set `oErrTimeout`.
  - From WAIT_SYNC or COLLECT, go to FILL.
  - From SUM, go directly to DONE; `oErrSum` stays 0.
- FILL: write `FILL` at each remaining address (counter..FRAME_LEN-1), one per clk with `oWren`=1. After the last one, go to DONE. Incoming bytes are ignored.
- DONE: `oDone`=1; the RAM is not written. `oDone` falls only on the next start edge, which releases the packer.
- Arithmetic:
  - The byte counter is 9 bits internally; `oWrAddr` is its low 8 bits.
  - With FRAME_LEN=256 the last address is 255; the counter never wraps before the SUM transition.

## Timing
- `oWren`, `oWrAddr` and `oWrData` are registered: they are valid in the clk after the `iRxValid` cycle, and `oWren` is high for exactly 1 clk.
- `oReq` rises 1 clk after the start-edge cycle; `oDone` falls in the clk after the start edge.
- `oDone` rises 1 clk after the checksum byte's `iRxValid`, or 1 clk after the last FILL write.
- Back-to-back `iRxValid` on consecutive clks are accepted without loss.
- Reset mid-frame: outputs drop to 0 immediately (async). RAM contents are undefined and a new start is required.
- `iStart` edge in the same cycle as a timeout in DONE/IDLE cannot occur; the start edge has priority over any other IDLE/DONE action.

## Test plan
- Nominal frame: start, then `SYNC` + 144 bytes (value = index) + checksum (XOR of 0..143). Required response:
  - exactly one `oReq` pulse;
  - 144 writes to addresses 0..143 with data = address;
  - `oDone`=1 one clk after the checksum; both error flags 0.
- Bad checksum: same frame with checksum XOR 8'h01 -> `oDone`=1, `oErrSum`=1, RAM contents identical to the nominal frame.
- Leading garbage and sync-valued data: bytes 8'h00, 8'h5A before `SYNC`, and data byte 10 = 8'hA5 -> garbage is not written; address 10 holds 8'hA5.
- Timeout mid-frame (TIMEOUT=64): stop after 100 data bytes -> addresses 100..143 written with 8'h00 on consecutive clks, `oErrTimeout`=1, `oDone`=1.
- Restart handshake: while in DONE, pulse `iStart` -> `oDone` falls next clk and the error flags clear. A second `iStart` during COLLECT is ignored (no `oReq`).
- Async reset asserted at byte 50 -> all outputs 0 immediately. After release, a fresh start completes a nominal frame.
